// File: rtl/pipeline_ctrl6.sv
// Six-stage (F, D, D2, X, M, W) pipeline sequencer: holds per-stage instruction/valid
// registers and advances, freezes, bubbles or squashes them from hazard/redirect/memory stalls.
module pipeline_ctrl6 #(
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_in,
   input  logic             inst_in_valid,
   input  logic             stallF_req,
   input  logic             redirect,
   input  logic             mem_stall,
   output logic [31:0]      instF,
   output logic [31:0]      instD,
   output logic [31:0]      instD2,
   output logic [31:0]      instX,
   output logic [31:0]      instM,
   output logic [31:0]      instW,
   output logic             validF,
   output logic             validD,
   output logic             validD2,
   output logic             validX,
   output logic             validM,
   output logic             validW,
   output logic             pc_en,
   output logic             flush_young,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int S_F  = 0;
   localparam int S_D  = 1;
   localparam int S_D2 = 2;
   localparam int S_X  = 3;
   localparam int S_M  = 4;
   localparam int S_W  = 5;

   typedef enum logic [1:0] {
      ACT_NORMAL,
      ACT_MEM_STALL,
      ACT_REDIRECT,
      ACT_LOAD_USE
   } action_t;

   action_t          action;
   logic [31:0]      inst_q  [6];
   logic [31:0]      inst_d  [6];
   logic             valid_q [6];
   logic             valid_d [6];
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Priority: memory stall freezes everything, then redirect, then load-use.
   always_comb begin
      if (mem_stall)       action = ACT_MEM_STALL;
      else if (redirect)   action = ACT_REDIRECT;
      else if (stallF_req) action = ACT_LOAD_USE;
      else                 action = ACT_NORMAL;
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      inst_d      = inst_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (action)
         ACT_NORMAL: begin
            inst_d[S_F]  = inst_in_valid ? inst_in : NOP_INST;
            valid_d[S_F] = inst_in_valid;
            for (int i = S_D; i <= S_W; i++) begin
               inst_d[i]  = inst_q[i-1];
               valid_d[i] = valid_q[i-1];
            end
         end
         ACT_MEM_STALL: begin
            inst_d[S_W]  = NOP_INST;
            valid_d[S_W] = 1'b0;
         end
         ACT_REDIRECT: begin
            // D2 is wrong-path, so X takes a bubble rather than D2's word.
            for (int i = S_F; i <= S_X; i++) begin
               inst_d[i]  = NOP_INST;
               valid_d[i] = 1'b0;
            end
            inst_d[S_M]  = inst_q[S_X];
            valid_d[S_M] = valid_q[S_X];
            inst_d[S_W]  = inst_q[S_M];
            valid_d[S_W] = valid_q[S_M];
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
         ACT_LOAD_USE: begin
            inst_d[S_D]  = NOP_INST;
            valid_d[S_D] = 1'b0;
            for (int i = S_D2; i <= S_W; i++) begin
               inst_d[i]  = inst_q[i-1];
               valid_d[i] = valid_q[i-1];
            end
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) begin
            inst_q[i]  <= NOP_INST;
            valid_q[i] <= 1'b0;
         end
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         inst_q      <= inst_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      pc_en       = 1'b0;
      flush_young = 1'b0;
      if (!rst) begin
         pc_en       = (action == ACT_NORMAL) || (action == ACT_REDIRECT);
         flush_young = (action == ACT_REDIRECT);
      end
   end

   assign instF   = inst_q[S_F];
   assign instD   = inst_q[S_D];
   assign instD2  = inst_q[S_D2];
   assign instX   = inst_q[S_X];
   assign instM   = inst_q[S_M];
   assign instW   = inst_q[S_W];
   assign validF  = valid_q[S_F];
   assign validD  = valid_q[S_D];
   assign validD2 = valid_q[S_D2];
   assign validX  = valid_q[S_X];
   assign validM  = valid_q[S_M];
   assign validW  = valid_q[S_W];
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
